// File: rtl/mux_pkg.sv
// Shared helpers for the arbitrated mux family: select-width derivation and channel limit.
package mux_pkg;

    localparam int MAX_N = 16;

    // Bits needed to index n channels; never less than 1 so N=2 still has a select bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin search: first requesting channel at or after ptr, wrapping at N.
module rr_grant
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [SEL_W:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
            if (req[idx[SEL_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-input valid/ready round-robin mux with a one-entry registered output stage.
// Optional channel locking is built when RR_MUX_LOCK_EN is defined (adds port in_lock).
module rr_mux_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*WIDTH-1:0]    in_data,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [clog2(N)-1:0]   out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef RR_MUX_LOCK_EN
    ,
    input  logic [N-1:0]          in_lock
`endif
);

    localparam int SEL_W = clog2(N);

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("rr_mux_arbiter: N out of range 2..16");
    end

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] g;
    logic             g_any;
    logic             free;
    logic             accept;
    logic [SEL_W:0]   g_inc;
    logic [SEL_W-1:0] ptr_nxt;

    rr_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_grant (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

`ifdef RR_MUX_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;

    // A locked channel owns the grant outright; other requests are ignored until it unlocks.
    assign g     = locked ? lock_ch : rr_idx;
    assign g_any = locked ? in_valid[lock_ch] : rr_any;
`else
    assign g     = rr_idx;
    assign g_any = rr_any;
`endif

    assign free    = !out_valid || out_ready;
    assign accept  = rst_n && free && g_any;
    assign g_inc   = {1'b0, g} + (SEL_W+1)'(1);
    assign ptr_nxt = (g_inc == (SEL_W+1)'(N)) ? '0 : g_inc[SEL_W-1:0];

    always_comb begin
        in_ready    = '0;
        in_ready[g] = accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[g*WIDTH +: WIDTH];
            out_sel   <= g;
`ifdef RR_MUX_LOCK_EN
            if (in_lock[g]) begin
                locked  <= 1'b1;
                lock_ch <= g;
            end else begin
                locked  <= 1'b0;
                ptr     <= ptr_nxt;
            end
`else
            ptr       <= ptr_nxt;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: N=4 main instance plus an N=3 instance for wrap checks.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_sel;
    logic        a_out_valid;
    logic        a_out_ready;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_sel;
    logic        b_out_valid;
    logic        b_out_ready;

`ifdef RR_MUX_LOCK_EN
    logic [3:0]  a_in_lock;
    logic [2:0]  b_in_lock;
`endif

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.WIDTH(8), .N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
`ifdef RR_MUX_LOCK_EN
        ,
        .in_lock   (a_in_lock)
`endif
    );

    rr_mux_arbiter #(.WIDTH(8), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
`ifdef RR_MUX_LOCK_EN
        ,
        .in_lock   (b_in_lock)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 4'b1111;
        #1;
        total++; if (a_in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", a_in_ready); end
        tick();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
        total++; if (a_out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", a_out_data); end
        total++; if (a_out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", a_out_sel); end
        total++; if (dut4.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut4.ptr); end
        a_in_valid = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        a_out_ready = 1'b1;
        a_in_data   = {8'h33, 8'hA5, 8'h22, 8'h11};
        a_in_valid  = 4'b0100;
        #1;
        total++; if (a_in_ready !== 4'b0100) begin bad++; $display("FAIL single_in_ready got=%b exp=0100", a_in_ready); end
        tick();
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", a_out_valid); end
        total++; if (a_out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", a_out_data); end
        total++; if (a_out_sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d exp=2", a_out_sel); end
        total++; if (dut4.ptr !== 2'd3) begin bad++; $display("FAIL single_ptr got=%0d exp=3", dut4.ptr); end
        a_in_valid = 4'b0000;
        #1;
        total++; if (a_in_ready !== 4'b0000) begin bad++; $display("FAIL idle_in_ready got=%b exp=0000", a_in_ready); end
        tick();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", a_out_valid); end
        total++; if (a_out_data !== 8'hA5) begin bad++; $display("FAIL drain_data_hold got=%h exp=a5", a_out_data); end
        total++; if (dut4.ptr !== 2'd3) begin bad++; $display("FAIL idle_ptr got=%0d exp=3", dut4.ptr); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        a_in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_sel = 2'(i % 4);
            tick();
            total++; if (a_out_valid !== 1'b1 || a_out_sel !== exp_sel || a_out_data !== (8'h10 + 8'(exp_sel))) begin
                bad++; $display("FAIL rr_beat%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                                i, a_out_valid, a_out_sel, a_out_data, exp_sel, 8'h10 + 8'(exp_sel));
            end
        end
    endtask

    task automatic test_stall();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready%0d got=%b exp=0000", i, a_in_ready); end
            tick();
            total++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd0 || a_out_data !== 8'h10) begin
                bad++; $display("FAIL stall_hold%0d got v=%b sel=%0d data=%h exp v=1 sel=0 data=10",
                                i, a_out_valid, a_out_sel, a_out_data);
            end
        end
        total++; if (dut4.ptr !== 2'd1) begin bad++; $display("FAIL stall_ptr got=%0d exp=1", dut4.ptr); end
        a_out_ready = 1'b1;
        a_in_valid  = 4'b0010;
        #1;
        total++; if (a_in_ready !== 4'b0010) begin bad++; $display("FAIL reload_in_ready got=%b exp=0010", a_in_ready); end
        tick();
        total++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd1 || a_out_data !== 8'h11) begin
            bad++; $display("FAIL reload_beat got v=%b sel=%0d data=%h exp v=1 sel=1 data=11",
                            a_out_valid, a_out_sel, a_out_data);
        end
        a_in_valid = 4'b0000;
        tick();
        total++; if (a_out_valid !== 1'b0 || a_out_sel !== 2'd1 || a_out_data !== 8'h11) begin
            bad++; $display("FAIL after_drain got v=%b sel=%0d data=%h exp v=0 sel=1 data=11",
                            a_out_valid, a_out_sel, a_out_data);
        end
        total++; if (dut4.ptr !== 2'd2) begin bad++; $display("FAIL after_drain_ptr got=%0d exp=2", dut4.ptr); end
    endtask

    task automatic test_reset_mid();
        a_in_valid = 4'b1000;
        tick();
        a_out_ready = 1'b0;
        a_in_valid  = 4'b0000;
        tick();
        total++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd3) begin
            bad++; $display("FAIL held_before_reset got v=%b sel=%0d exp v=1 sel=3", a_out_valid, a_out_sel);
        end
        rst_n      = 1'b0;
        a_in_valid = 4'b1111;
        #1;
        total++; if (a_in_ready !== 4'b0000) begin bad++; $display("FAIL midreset_in_ready got=%b exp=0000", a_in_ready); end
        tick();
        total++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_sel !== 2'd0 || dut4.ptr !== 2'd0) begin
            bad++; $display("FAIL midreset_state got v=%b data=%h sel=%0d ptr=%0d exp v=0 data=00 sel=0 ptr=0",
                            a_out_valid, a_out_data, a_out_sel, dut4.ptr);
        end
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        #1;
        total++; if (a_in_ready !== 4'b0001) begin bad++; $display("FAIL postreset_in_ready got=%b exp=0001", a_in_ready); end
        tick();
        total++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd0 || a_out_data !== 8'h10) begin
            bad++; $display("FAIL postreset_beat got v=%b sel=%0d data=%h exp v=1 sel=0 data=10",
                            a_out_valid, a_out_sel, a_out_data);
        end
        a_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap_n3();
        b_in_data  = {8'hC2, 8'hC1, 8'hC0};
        b_in_valid = 3'b010;
        tick();
        total++; if (b_out_sel !== 2'd1 || dut3.ptr !== 2'd2) begin
            bad++; $display("FAIL n3_setup got sel=%0d ptr=%0d exp sel=1 ptr=2", b_out_sel, dut3.ptr);
        end
        b_in_valid = 3'b100;
        tick();
        total++; if (b_out_valid !== 1'b1 || b_out_sel !== 2'd2 || b_out_data !== 8'hC2) begin
            bad++; $display("FAIL n3_ch2 got v=%b sel=%0d data=%h exp v=1 sel=2 data=c2", b_out_valid, b_out_sel, b_out_data);
        end
        total++; if (dut3.ptr !== 2'd0) begin bad++; $display("FAIL n3_wrap_ptr got=%0d exp=0", dut3.ptr); end
        b_in_valid = 3'b101;
        #1;
        total++; if (b_in_ready !== 3'b001) begin bad++; $display("FAIL n3_in_ready got=%b exp=001", b_in_ready); end
        tick();
        total++; if (b_out_sel !== 2'd0 || b_out_data !== 8'hC0) begin
            bad++; $display("FAIL n3_grant got sel=%0d data=%h exp sel=0 data=c0", b_out_sel, b_out_data);
        end
        b_in_valid = 3'b000;
    endtask

`ifdef RR_MUX_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_sel [4];
        logic [3:0] vld [4];
        logic [3:0] lck [4];
        exp_sel = '{2'd1, 2'd1, 2'd1, 2'd2};
        vld     = '{4'b0010, 4'b1111, 4'b1111, 4'b1111};
        lck     = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        a_in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 4; i++) begin
            a_in_valid = vld[i];
            a_in_lock  = lck[i];
            tick();
            total++; if (a_out_valid !== 1'b1 || a_out_sel !== exp_sel[i]) begin
                bad++; $display("FAIL lock_beat%0d got v=%b sel=%0d exp v=1 sel=%0d", i, a_out_valid, a_out_sel, exp_sel[i]);
            end
        end
        a_in_valid = 4'b0000;
        a_in_lock  = 4'b0000;
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_in_valid  = '0;
        a_out_ready = 1'b1;
        b_in_data   = '0;
        b_in_valid  = '0;
        b_out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        a_in_lock   = '0;
        b_in_lock   = '0;
`endif
        tick();
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_wrap_n3();
`ifdef RR_MUX_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
